// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and client IDs for the memory port arbiter.
// Values mirror the external memory interface widths used across the core.
package mem_arb_pkg;

    localparam int MEM_ADDR_BITS  = 28;
    localparam int MEM_DATA_BITS  = 128;
    localparam int MEM_TAG_BITS   = 5;
    localparam int DATA_BEATS     = 4;
    localparam int MEM_MASK_BITS  = MEM_DATA_BITS / 8;
    localparam int CLIENT_TAG_BITS = MEM_TAG_BITS - 1;
    localparam int BEAT_CNT_BITS  = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } arb_state_t;

    function automatic logic is_last_beat(input logic [BEAT_CNT_BITS-1:0] cnt);
        return cnt == BEAT_CNT_BITS'(DATA_BEATS - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins outright, and on
// contention the client that did not win last time is chosen.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = CLIENT_IC;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[CLIENT_DC]) begin
            grant = CLIENT_DC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between the icache and dcache: round-robin
// address arbitration, port lock for write beats, tag-based response steering.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ic_mem_req_valid,
    output logic                       ic_mem_req_ready,
    input  logic                       ic_mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic [CLIENT_TAG_BITS-1:0] ic_mem_req_tag,
    input  logic                       ic_mem_req_data_valid,
    output logic                       ic_mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0]   ic_mem_req_data_mask,
    output logic                       ic_mem_resp_valid,
    output logic [CLIENT_TAG_BITS-1:0] ic_mem_resp_tag,
    output logic [MEM_DATA_BITS-1:0]   ic_mem_resp_data,

    input  logic                       dc_mem_req_valid,
    output logic                       dc_mem_req_ready,
    input  logic                       dc_mem_req_rw,
    input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic [CLIENT_TAG_BITS-1:0] dc_mem_req_tag,
    input  logic                       dc_mem_req_data_valid,
    output logic                       dc_mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [MEM_MASK_BITS-1:0]   dc_mem_req_data_mask,
    output logic                       dc_mem_resp_valid,
    output logic [CLIENT_TAG_BITS-1:0] dc_mem_resp_tag,
    output logic [MEM_DATA_BITS-1:0]   dc_mem_resp_data,

    output logic                       mem_req_valid,
    output logic                       mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic [MEM_TAG_BITS-1:0]    mem_req_tag,
    input  logic                       mem_req_ready,
    output logic                       mem_req_data_valid,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_MASK_BITS-1:0]   mem_req_data_mask,
    input  logic                       mem_req_data_ready,
    input  logic                       mem_resp_valid,
    input  logic [MEM_TAG_BITS-1:0]    mem_resp_tag,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    arb_state_t               state_q, state_d;
    logic [BEAT_CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;

    logic                       arb_grant;
    logic                       sel_valid;
    logic                       sel_rw;
    logic [MEM_ADDR_BITS-1:0]   sel_addr;
    logic [CLIENT_TAG_BITS-1:0] sel_tag;
    logic                       sel_data_valid;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({dc_mem_req_valid, ic_mem_req_valid}),
        .last_grant (last_grant_q),
        .grant      (arb_grant)
    );

    // Request and data fields always follow the held grant; only the
    // valid/ready handshakes are gated by the FSM state.
    assign sel_valid      = (grant_q == CLIENT_DC) ? dc_mem_req_valid      : ic_mem_req_valid;
    assign sel_rw         = (grant_q == CLIENT_DC) ? dc_mem_req_rw         : ic_mem_req_rw;
    assign sel_addr       = (grant_q == CLIENT_DC) ? dc_mem_req_addr       : ic_mem_req_addr;
    assign sel_tag        = (grant_q == CLIENT_DC) ? dc_mem_req_tag        : ic_mem_req_tag;
    assign sel_data_valid = (grant_q == CLIENT_DC) ? dc_mem_req_data_valid : ic_mem_req_data_valid;

    assign mem_req_rw        = sel_rw;
    assign mem_req_addr      = sel_addr;
    assign mem_req_tag       = {grant_q, sel_tag};
    assign mem_req_data_bits = (grant_q == CLIENT_DC) ? dc_mem_req_data_bits : ic_mem_req_data_bits;
    assign mem_req_data_mask = (grant_q == CLIENT_DC) ? dc_mem_req_data_mask : ic_mem_req_data_mask;

    // Responses bypass the FSM entirely so reads keep returning during writes.
    assign ic_mem_resp_valid = mem_resp_valid && (mem_resp_tag[MEM_TAG_BITS-1] == CLIENT_IC);
    assign dc_mem_resp_valid = mem_resp_valid && (mem_resp_tag[MEM_TAG_BITS-1] == CLIENT_DC);
    assign ic_mem_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
    assign dc_mem_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;

    always_comb begin
        state_d               = state_q;
        beat_cnt_d            = beat_cnt_q;
        grant_d               = grant_q;
        last_grant_d          = last_grant_q;
        mem_req_valid         = 1'b0;
        mem_req_data_valid    = 1'b0;
        ic_mem_req_ready      = 1'b0;
        dc_mem_req_ready      = 1'b0;
        ic_mem_req_data_ready = 1'b0;
        dc_mem_req_data_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (ic_mem_req_valid || dc_mem_req_valid) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    state_d      = REQ;
                end
            end
            REQ: begin
                mem_req_valid    = sel_valid;
                ic_mem_req_ready = (grant_q == CLIENT_IC) && mem_req_ready;
                dc_mem_req_ready = (grant_q == CLIENT_DC) && mem_req_ready;
                if (sel_valid && mem_req_ready) begin
                    if (sel_rw) begin
                        state_d    = WDATA;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WDATA: begin
                mem_req_data_valid    = sel_data_valid;
                ic_mem_req_data_ready = (grant_q == CLIENT_IC) && mem_req_data_ready;
                dc_mem_req_data_ready = (grant_q == CLIENT_DC) && mem_req_data_ready;
                if (sel_data_valid && mem_req_data_ready) begin
                    if (is_last_beat(beat_cnt_q)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // last_grant resets to the dcache so the icache wins the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            grant_q      <= CLIENT_IC;
            last_grant_q <= CLIENT_DC;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                       cv_valid [2];
    logic                       cv_rw    [2];
    logic [MEM_ADDR_BITS-1:0]   cv_addr  [2];
    logic [CLIENT_TAG_BITS-1:0] cv_tag   [2];
    logic                       cv_dvalid[2];
    logic [MEM_DATA_BITS-1:0]   cv_dbits [2];
    logic [MEM_MASK_BITS-1:0]   cv_dmask [2];

    logic                       o_req_ready [2];
    logic                       o_data_ready[2];
    logic                       o_resp_valid[2];
    logic [CLIENT_TAG_BITS-1:0] o_resp_tag  [2];
    logic [MEM_DATA_BITS-1:0]   o_resp_data [2];

    logic                       m_req_ready, m_data_ready, m_resp_valid;
    logic [MEM_TAG_BITS-1:0]    m_resp_tag;
    logic [MEM_DATA_BITS-1:0]   m_resp_data;

    logic                       x_req_valid, x_req_rw, x_data_valid;
    logic [MEM_ADDR_BITS-1:0]   x_req_addr;
    logic [MEM_TAG_BITS-1:0]    x_req_tag;
    logic [MEM_DATA_BITS-1:0]   x_data_bits;
    logic [MEM_MASK_BITS-1:0]   x_data_mask;

    mem_port_arbiter dut (
        .clk                   (clk),
        .reset                 (reset),
        .ic_mem_req_valid      (cv_valid[0]),
        .ic_mem_req_ready      (o_req_ready[0]),
        .ic_mem_req_rw         (cv_rw[0]),
        .ic_mem_req_addr       (cv_addr[0]),
        .ic_mem_req_tag        (cv_tag[0]),
        .ic_mem_req_data_valid (cv_dvalid[0]),
        .ic_mem_req_data_ready (o_data_ready[0]),
        .ic_mem_req_data_bits  (cv_dbits[0]),
        .ic_mem_req_data_mask  (cv_dmask[0]),
        .ic_mem_resp_valid     (o_resp_valid[0]),
        .ic_mem_resp_tag       (o_resp_tag[0]),
        .ic_mem_resp_data      (o_resp_data[0]),
        .dc_mem_req_valid      (cv_valid[1]),
        .dc_mem_req_ready      (o_req_ready[1]),
        .dc_mem_req_rw         (cv_rw[1]),
        .dc_mem_req_addr       (cv_addr[1]),
        .dc_mem_req_tag        (cv_tag[1]),
        .dc_mem_req_data_valid (cv_dvalid[1]),
        .dc_mem_req_data_ready (o_data_ready[1]),
        .dc_mem_req_data_bits  (cv_dbits[1]),
        .dc_mem_req_data_mask  (cv_dmask[1]),
        .dc_mem_resp_valid     (o_resp_valid[1]),
        .dc_mem_resp_tag       (o_resp_tag[1]),
        .dc_mem_resp_data      (o_resp_data[1]),
        .mem_req_valid         (x_req_valid),
        .mem_req_rw            (x_req_rw),
        .mem_req_addr          (x_req_addr),
        .mem_req_tag           (x_req_tag),
        .mem_req_ready         (m_req_ready),
        .mem_req_data_valid    (x_data_valid),
        .mem_req_data_bits     (x_data_bits),
        .mem_req_data_mask     (x_data_mask),
        .mem_req_data_ready    (m_data_ready),
        .mem_resp_valid        (m_resp_valid),
        .mem_resp_tag          (m_resp_tag),
        .mem_resp_data         (m_resp_data)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level view of the port: who owns it, whether the address
    // has gone out, how many beats are done, and who wins the next tie.
    bit mdl_busy = 0;
    bit mdl_addr_done = 0;
    int mdl_owner = 0;
    int mdl_beats = 0;
    int mdl_prefer = 0;

    bit exp_req_ready[2], exp_data_ready[2];
    bit exp_x_req_valid, exp_x_data_valid;
    bit hs_req[2], hs_data[2];
    bit clr_clients = 0;
    bit cl_in_data[2];
    int cl_beat[2];

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        int o;
        o = mdl_owner;
        exp_x_req_valid  = mdl_busy && !mdl_addr_done && cv_valid[o];
        exp_x_data_valid = mdl_busy && mdl_addr_done && cv_dvalid[o];
        for (int c = 0; c < 2; c++) begin
            exp_req_ready[c]  = mdl_busy && !mdl_addr_done && (o == c) && m_req_ready;
            exp_data_ready[c] = mdl_busy && mdl_addr_done && (o == c) && m_data_ready;
            cmp($sformatf("req_ready[%0d]", c), o_req_ready[c], exp_req_ready[c]);
            cmp($sformatf("data_ready[%0d]", c), o_data_ready[c], exp_data_ready[c]);
            cmp($sformatf("resp_valid[%0d]", c), o_resp_valid[c],
                m_resp_valid && (m_resp_tag[MEM_TAG_BITS-1] == c[0]));
            cmp($sformatf("resp_tag[%0d]", c), o_resp_tag[c], m_resp_tag[CLIENT_TAG_BITS-1:0]);
            cmp($sformatf("resp_data[%0d]", c), o_resp_data[c], m_resp_data);
        end
        cmp("mem_req_valid", x_req_valid, exp_x_req_valid);
        cmp("mem_req_data_valid", x_data_valid, exp_x_data_valid);
        if (exp_x_req_valid) begin
            cmp("mem_req_rw", x_req_rw, cv_rw[o]);
            cmp("mem_req_addr", x_req_addr, cv_addr[o]);
            cmp("mem_req_tag", x_req_tag, {o[0], cv_tag[o]});
        end
        if (exp_x_data_valid) begin
            cmp("mem_req_data_bits", x_data_bits, cv_dbits[o]);
            cmp("mem_req_data_mask", x_data_mask, cv_dmask[o]);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            hs_req[c]  = reset && cv_valid[c] && exp_req_ready[c];
            hs_data[c] = reset && cv_dvalid[c] && exp_data_ready[c];
        end
        if (!reset) begin
            mdl_busy      = 0;
            mdl_addr_done = 0;
            mdl_beats     = 0;
            mdl_prefer    = 0;
            clr_clients   = 1;
        end else if (!mdl_busy) begin
            if (cv_valid[0] || cv_valid[1]) begin
                if (cv_valid[0] && cv_valid[1]) mdl_owner = mdl_prefer;
                else mdl_owner = cv_valid[1] ? 1 : 0;
                mdl_prefer    = 1 - mdl_owner;
                mdl_busy      = 1;
                mdl_addr_done = 0;
            end
        end else if (!mdl_addr_done) begin
            if (exp_x_req_valid && m_req_ready) begin
                if (cv_rw[mdl_owner]) begin
                    mdl_addr_done = 1;
                    mdl_beats     = 0;
                end else begin
                    mdl_busy = 0;
                end
            end
        end else if (exp_x_data_valid && m_data_ready) begin
            mdl_beats++;
            if (mdl_beats == DATA_BEATS) mdl_busy = 0;
        end
    endtask

    task automatic cycle_end();
        checkOutput();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int c = 0; c < 2; c++) begin
            cv_valid[c]   = 0;
            cv_rw[c]      = 0;
            cv_addr[c]    = '0;
            cv_tag[c]     = '0;
            cv_dvalid[c]  = 0;
            cv_dbits[c]   = '0;
            cv_dmask[c]   = '1;
            cl_in_data[c] = 0;
            cl_beat[c]    = 0;
        end
        m_req_ready  = 0;
        m_data_ready = 0;
        m_resp_valid = 0;
        m_resp_tag   = '0;
        m_resp_data  = '0;
    endtask

    task automatic do_reset();
        reset = 0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cycle_end();
        end
        reset = 1;
        clr_clients = 0;
    endtask

    // Random clients obey the protocol: fields held until accepted, write
    // beats only after the address handshake (plus rare early strays).
    task automatic applyStimulus();
        for (int c = 0; c < 2; c++) begin
            if (clr_clients) begin
                cv_valid[c]   = 0;
                cl_in_data[c] = 0;
            end else begin
                if (hs_req[c]) begin
                    cv_valid[c] = 0;
                    if (cv_rw[c]) begin
                        cl_in_data[c] = 1;
                        cl_beat[c]    = 0;
                    end
                end
                if (hs_data[c]) begin
                    cl_beat[c]++;
                    if (cl_beat[c] == DATA_BEATS) cl_in_data[c] = 0;
                end
            end
            if (!cv_valid[c] && !cl_in_data[c] && $urandom_range(0, 3) == 0) begin
                cv_valid[c] = 1;
                cv_rw[c]    = 1'($urandom);
                cv_addr[c]  = MEM_ADDR_BITS'($urandom);
                cv_tag[c]   = CLIENT_TAG_BITS'($urandom);
            end
            cv_dvalid[c] = cl_in_data[c] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            cv_dbits[c]  = {$urandom, $urandom, $urandom, $urandom};
            cv_dmask[c]  = MEM_MASK_BITS'($urandom);
        end
        clr_clients  = 0;
        m_req_ready  = 1'($urandom);
        m_data_ready = 1'($urandom);
        m_resp_valid = ($urandom_range(0, 2) == 0);
        m_resp_tag   = MEM_TAG_BITS'($urandom);
        m_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        reset        = ($urandom_range(0, 63) != 0);
    endtask

    logic [MEM_DATA_BITS-1:0] seen[4];
    logic [MEM_DATA_BITS-1:0] seen_exp[4];
    int nhs;
    int beat;
    bit got;

    initial begin
        seen_exp[0] = 128'hA;
        seen_exp[1] = 128'hB;
        seen_exp[2] = 128'hC;
        seen_exp[3] = 128'hD;
        reset = 0;
        clear_inputs();
        @(negedge clk);
        cycle_end();
        @(negedge clk);
        cmp("rst_ic_req_ready", o_req_ready[0], 0);
        cmp("rst_dc_req_ready", o_req_ready[1], 0);
        cmp("rst_mem_req_valid", x_req_valid, 0);
        cmp("rst_mem_data_valid", x_data_valid, 0);
        cycle_end();
        reset = 1;
        clr_clients = 0;

        // icache read, tag 3, address 0x100
        cv_valid[0] = 1; cv_rw[0] = 0; cv_addr[0] = 28'h100; cv_tag[0] = 4'd3;
        m_req_ready = 1;
        @(negedge clk);
        cmp("t1_bubble_valid", x_req_valid, 0);
        cycle_end();
        @(negedge clk);
        cmp("t1_req_valid", x_req_valid, 1);
        cmp("t1_req_tag", x_req_tag, 5'b0_0011);
        cmp("t1_req_addr", x_req_addr, 28'h100);
        cmp("t1_ic_ready", o_req_ready[0], 1);
        cycle_end();
        cv_valid[0] = 0;
        m_resp_valid = 1; m_resp_tag = 5'b0_0011; m_resp_data = 128'h1234;
        @(negedge clk);
        cmp("t1_ic_resp_valid", o_resp_valid[0], 1);
        cmp("t1_dc_resp_valid", o_resp_valid[1], 0);
        cmp("t1_ic_resp_tag", o_resp_tag[0], 4'd3);
        cycle_end();
        m_resp_valid = 0;

        // simultaneous reads out of reset alternate ic, dc, ic, dc
        do_reset();
        for (int r = 0; r < 2; r++) begin
            cv_valid[0] = 1; cv_rw[0] = 0; cv_addr[0] = 28'h10 + 28'(r); cv_tag[0] = 4'd1;
            cv_valid[1] = 1; cv_rw[1] = 0; cv_addr[1] = 28'h20 + 28'(r); cv_tag[1] = 4'd2;
            m_req_ready = 1;
            @(negedge clk);
            cycle_end();
            @(negedge clk);
            cmp("t2_ic_first", o_req_ready[0], 1);
            cmp("t2_dc_waits", o_req_ready[1], 0);
            cycle_end();
            cv_valid[0] = 0;
            @(negedge clk);
            cycle_end();
            @(negedge clk);
            cmp("t2_dc_second", o_req_ready[1], 1);
            cmp("t2_dc_tag_msb", x_req_tag[MEM_TAG_BITS-1], 1);
            cycle_end();
            cv_valid[1] = 0;
            @(negedge clk);
            cycle_end();
        end

        // dcache write with early data, toggling data ready, mid-write response
        cv_valid[1] = 1; cv_rw[1] = 1; cv_addr[1] = 28'h40; cv_tag[1] = 4'd7;
        cv_dvalid[1] = 1; cv_dbits[1] = 128'hA; cv_dmask[1] = '1;
        m_req_ready = 1; m_data_ready = 1;
        @(negedge clk);
        cmp("t5_early_data_ready", o_data_ready[1], 0);
        cmp("t5_early_ext_dvalid", x_data_valid, 0);
        cycle_end();
        cv_valid[0] = 1; cv_rw[0] = 0; cv_addr[0] = 28'h200; cv_tag[0] = 4'd1;
        @(negedge clk);
        cmp("t5_req_data_ready", o_data_ready[1], 0);
        cmp("t5_req_ext_dvalid", x_data_valid, 0);
        cmp("t3_dc_req_ready", o_req_ready[1], 1);
        cycle_end();
        cv_valid[1] = 0;
        nhs = 0;
        beat = 0;
        for (int k = 0; k < 40 && beat < DATA_BEATS; k++) begin
            m_data_ready = k[0];
            cv_dbits[1]  = 128'(10 + beat);
            m_resp_valid = (k == 3);
            m_resp_tag   = 5'b1_0111;
            @(negedge clk);
            cmp("t3_ic_req_ready_held", o_req_ready[0], 0);
            if (k == 3) begin
                cmp("t4_dc_resp_valid", o_resp_valid[1], 1);
                cmp("t4_dc_resp_tag", o_resp_tag[1], 4'd7);
                cmp("t4_ic_resp_valid", o_resp_valid[0], 0);
            end
            if (x_data_valid && m_data_ready && nhs < 4) begin
                seen[nhs] = x_data_bits;
                nhs++;
            end
            cycle_end();
            if (hs_data[1]) beat++;
        end
        m_resp_valid = 0;
        cv_dvalid[1] = 0;
        cmp("t3_beat_count", 32'(nhs), 4);
        for (int i = 0; i < 4; i++) cmp($sformatf("t3_beat%0d", i), seen[i], seen_exp[i]);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            cycle_end();
            if (hs_req[0]) begin
                got = 1;
                cv_valid[0] = 0;
            end
        end
        cmp("t3_ic_granted_after", got, 1);

        // reset after two beats of an icache write aborts to idle
        cv_valid[0] = 1; cv_rw[0] = 1; cv_addr[0] = 28'h80; cv_tag[0] = 4'd2;
        cv_dvalid[0] = 1; cv_dbits[0] = 128'h55; m_req_ready = 1; m_data_ready = 1;
        @(negedge clk);
        cycle_end();
        @(negedge clk);
        cycle_end();
        cv_valid[0] = 0;
        for (int i = 0; i < 2; i++) begin
            cv_dbits[0] = 128'(32'h60 + i);
            @(negedge clk);
            cycle_end();
        end
        reset = 0;
        @(negedge clk);
        cycle_end();
        reset = 1;
        clr_clients = 0;
        cv_dvalid[0] = 0;
        cv_valid[0] = 1; cv_rw[0] = 0; cv_addr[0] = 28'h300; cv_tag[0] = 4'd5;
        @(negedge clk);
        cmp("t6_idle_req_valid", x_req_valid, 0);
        cmp("t6_idle_data_valid", x_data_valid, 0);
        cmp("t6_idle_ic_data_ready", o_data_ready[0], 0);
        cmp("t6_idle_ic_req_ready", o_req_ready[0], 0);
        cycle_end();
        @(negedge clk);
        cmp("t6_regrant_valid", x_req_valid, 1);
        cmp("t6_regrant_tag", x_req_tag, 5'b0_0101);
        cmp("t6_regrant_ready", o_req_ready[0], 1);
        cycle_end();
        cv_valid[0] = 0;
        @(negedge clk);
        cycle_end();

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            @(negedge clk);
            cycle_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
